// File: rtl/calc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_pkg: constants shared by the calculator input conditioner        |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package calc_pkg;

  localparam logic DB_RELEASED = 1'b0;
  localparam logic DB_PRESSED  = 1'b1;

  localparam int DEBOUNCE_CYCLES_DEFAULT = 500000;

  localparam int OPERAND_LSB = 0;
  localparam int OPERAND_MSB = 7;
  localparam int OPCODE_LSB  = 8;
  localparam int OPCODE_MSB  = 11;

endpackage
`default_nettype wire

// File: rtl/btn_debounce.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | btn_debounce: 2-flop sync, polarity fix, stability counter, FSM      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module btn_debounce
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 19,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic clock,
  input  logic reset_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_press
);

  localparam logic             c_RAW_RELEASED = (BTN_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] c_CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_state;

  logic w_synced;
  logic w_level_now;
  logic w_differs;
  logic w_flip;

  assign w_synced    = r_sync2 ^ c_RAW_RELEASED;
  assign w_level_now = (r_state == DB_PRESSED);
  assign w_differs   = (w_synced != w_level_now);
  assign w_flip      = w_differs && (r_cnt == c_CNT_LAST);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sync1 <= c_RAW_RELEASED;
      r_sync2 <= c_RAW_RELEASED;
      r_cnt   <= '0;
      r_state <= DB_RELEASED;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      // Any sample agreeing with the current level restarts the stability window.
      if (!w_differs) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt   <= '0;
        r_state <= w_level_now ? DB_RELEASED : DB_PRESSED;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = w_level_now;
  assign o_press = w_flip && (r_state == DB_RELEASED);

endmodule
`default_nettype wire

// File: rtl/calc_input_conditioner.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | calc_input_conditioner: debounced Enter/Clear strobes, operand latch |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module calc_input_conditioner
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int CNT_W           = 19,
  parameter int BTN_ACTIVE_LOW  = 1
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [11:0] Switchs,
  input  logic        EnterBtn,
  input  logic        ClearBtn,
  output logic        EnterLevel,
  output logic        ClearLevel,
  output logic        EnterPulse,
  output logic        ClearPulse,
  output logic [7:0]  Operand,
  output logic [3:0]  Opcode
);

  logic [11:0] r_sw1;
  logic [11:0] r_sw2;
  logic        r_enter_pulse;
  logic        r_clear_pulse;
  logic [7:0]  r_operand;
  logic [3:0]  r_opcode;

  logic w_enter_press;
  logic w_clear_press;

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_enter_db (
    .clock   (clock),
    .reset_n (reset_n),
    .i_btn   (EnterBtn),
    .o_level (EnterLevel),
    .o_press (w_enter_press)
  );

  btn_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .BTN_ACTIVE_LOW  (BTN_ACTIVE_LOW)
  ) u_clear_db (
    .clock   (clock),
    .reset_n (reset_n),
    .i_btn   (ClearBtn),
    .o_level (ClearLevel),
    .o_press (w_clear_press)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_sw1         <= '0;
      r_sw2         <= '0;
      r_enter_pulse <= 1'b0;
      r_clear_pulse <= 1'b0;
      r_operand     <= '0;
      r_opcode      <= '0;
    end else begin
      r_sw1         <= Switchs;
      r_sw2         <= r_sw1;
      r_clear_pulse <= w_clear_press;
      // Clear takes priority over a simultaneous Enter and suppresses its capture.
      r_enter_pulse <= w_enter_press && !w_clear_press;
      if (w_clear_press) begin
        r_operand <= '0;
        r_opcode  <= '0;
      end else if (w_enter_press) begin
        r_operand <= r_sw2[OPERAND_MSB:OPERAND_LSB];
        r_opcode  <= r_sw2[OPCODE_MSB:OPCODE_LSB];
      end
    end
  end

  assign EnterPulse = r_enter_pulse;
  assign ClearPulse = r_clear_pulse;
  assign Operand    = r_operand;
  assign Opcode     = r_opcode;

endmodule
`default_nettype wire
